wildcard_match_pipe: RTL and testbench



---
 rtl/wildcard_match_pkg.sv | 16 +
 rtl/wm_prio_enc.sv | 27 ++
 rtl/wildcard_match_pipe.sv | 116 +++++++++++
 tb/tb_wildcard_match_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wildcard_match_pkg.sv
// Shared types for the wildcard match pipeline: table entry layout and index constants.
package wildcard_match_pkg;

  // Widest pattern the table storage supports; narrower DATA_W values zero-extend.
  localparam int unsigned MAX_DATA_W = 32;

  // Index reported when no enabled entry matches.
  localparam int unsigned NO_HIT = 0;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] value;
    logic [MAX_DATA_W-1:0] mask;
    logic                  en;
  } entry_t;

endpackage

// File: rtl/wm_prio_enc.sv
// Priority encoder over a match vector; PRIO_HIGH picks highest or lowest set bit.
module wm_prio_enc
  import wildcard_match_pkg::*;
#(
  parameter int unsigned NUM_ENT   = 8,
  parameter int unsigned IDX_W     = $clog2(NUM_ENT),
  parameter bit          PRIO_HIGH = 1'b0
) (
  input  logic [NUM_ENT-1:0] vec,
  output logic               hit_c,
  output logic [IDX_W-1:0]   idx_c
);

  // Scan so the winning index is the last one assigned.
  always_comb begin
    idx_c = IDX_W'(NO_HIT);
    hit_c = |vec;
    for (int i = 0; i < int'(NUM_ENT); i++) begin
      if (PRIO_HIGH) begin
        if (vec[i]) idx_c = IDX_W'(i);
      end else begin
        if (vec[int'(NUM_ENT) - 1 - i]) idx_c = IDX_W'(int'(NUM_ENT) - 1 - i);
      end
    end
  end

endmodule

// File: rtl/wildcard_match_pipe.sv
// Two-stage programmable wildcard classifier: compare against all entries, then priority-encode.
module wildcard_match_pipe
  import wildcard_match_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_ENT   = 8,
  parameter int unsigned IDX_W     = $clog2(NUM_ENT),
  parameter int unsigned CNT_W     = 16,
  parameter bit          PRIO_HIGH = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_value,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic              cfg_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_hit,
  output logic [IDX_W-1:0]  out_idx,
  output logic [NUM_ENT-1:0] out_vec,
  output logic [CNT_W-1:0]  hit_cnt
);

  entry_t                tbl [NUM_ENT];
  logic                  idx_ok_c;
  logic [MAX_DATA_W-1:0] in_ext_c;
  logic [NUM_ENT-1:0]    match_c;
  logic                  s1_valid;
  logic [NUM_ENT-1:0]    s1_vec;
  logic                  enc_hit_c;
  logic [IDX_W-1:0]      enc_idx_c;

  // Out-of-range table indices only exist when NUM_ENT is not a power of two.
  if (NUM_ENT == (1 << IDX_W)) begin : g_idx_full
    assign idx_ok_c = 1'b1;
  end else begin : g_idx_part
    assign idx_ok_c = (cfg_idx < IDX_W'(NUM_ENT));
  end

  // Whole pipe advances together; the output register frees up when drained or empty.
  assign in_ready = !out_valid || out_ready;

  assign in_ext_c = MAX_DATA_W'(in_data);

  // Table writes land on the next edge, independent of pipeline stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_ENT); i++) tbl[i] <= '0;
    end else if (cfg_we && idx_ok_c) begin
      tbl[cfg_idx] <= '{value: MAX_DATA_W'(cfg_value),
                        mask:  MAX_DATA_W'(cfg_mask),
                        en:    cfg_en};
    end
  end

  // Per-entry compare; cleared mask bits are don't-care.
  always_comb begin
    match_c = '0;
    for (int i = 0; i < int'(NUM_ENT); i++) begin
      match_c[i] = tbl[i].en && (((in_ext_c ^ tbl[i].value) & tbl[i].mask) == '0);
    end
  end

  // Stage 1: capture compare vector against the table as it stands before any same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_vec <= match_c;
    end
  end

  wm_prio_enc #(
    .NUM_ENT   (NUM_ENT),
    .IDX_W     (IDX_W),
    .PRIO_HIGH (PRIO_HIGH)
  ) u_enc (
    .vec   (s1_vec),
    .hit_c (enc_hit_c),
    .idx_c (enc_idx_c)
  );

  // Stage 2: register the encoded result; held stable while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_idx   <= IDX_W'(NO_HIT);
      out_vec   <= '0;
    end else if (in_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_hit <= enc_hit_c;
        out_idx <= enc_idx_c;
        out_vec <= s1_vec;
      end
    end
  end

  // Saturating count of hit results handed downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt <= '0;
    end else if (out_valid && out_ready && out_hit && (hit_cnt != '1)) begin
      hit_cnt <= hit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wildcard_match_pipe.sv
// Bench for wildcard_match_pipe: two instances (low/high priority, 4/16-bit counters) on shared stimulus.
module tb_wildcard_match_pipe;

  localparam int unsigned DW = 8;
  localparam int unsigned NE = 8;
  localparam int unsigned IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we, cfg_en;
  logic [IW-1:0] cfg_idx;
  logic [DW-1:0] cfg_value, cfg_mask, in_data;
  logic          in_valid, out_ready;

  logic          lo_in_ready, lo_out_valid, lo_out_hit;
  logic [IW-1:0] lo_out_idx;
  logic [NE-1:0] lo_out_vec;
  logic [3:0]    lo_hit_cnt;
  logic          hi_in_ready, hi_out_valid, hi_out_hit;
  logic [IW-1:0] hi_out_idx;
  logic [NE-1:0] hi_out_vec;
  logic [15:0]   hi_hit_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  wildcard_match_pipe #(.DATA_W(DW), .NUM_ENT(NE), .IDX_W(IW), .CNT_W(4), .PRIO_HIGH(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_value(cfg_value),
    .cfg_mask(cfg_mask), .cfg_en(cfg_en), .in_valid(in_valid), .in_ready(lo_in_ready),
    .in_data(in_data), .out_valid(lo_out_valid), .out_ready(out_ready), .out_hit(lo_out_hit),
    .out_idx(lo_out_idx), .out_vec(lo_out_vec), .hit_cnt(lo_hit_cnt)
  );

  wildcard_match_pipe #(.DATA_W(DW), .NUM_ENT(NE), .IDX_W(IW), .CNT_W(16), .PRIO_HIGH(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_value(cfg_value),
    .cfg_mask(cfg_mask), .cfg_en(cfg_en), .in_valid(in_valid), .in_ready(hi_in_ready),
    .in_data(in_data), .out_valid(hi_out_valid), .out_ready(out_ready), .out_hit(hi_out_hit),
    .out_idx(hi_out_idx), .out_vec(hi_out_vec), .hit_cnt(hi_hit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NE-1:0] vec;
    logic          hit;
    logic [IW-1:0] lo;
    logic [IW-1:0] hi;
  } exp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [NE-1:0] vec;
    logic          hit;
    logic [IW-1:0] lo;
    logic [IW-1:0] hi;
  } vec_t;

  logic [DW-1:0] m_val  [NE];
  logic [DW-1:0] m_mask [NE];
  logic          m_en   [NE];
  exp_t          sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: search upward for the first match and downward for the last.
  function automatic exp_t model(input logic [DW-1:0] d);
    exp_t r;
    r = '0;
    for (int i = 0; i < int'(NE); i++)
      r.vec[i] = m_en[i] && (((d ^ m_val[i]) & m_mask[i]) == '0);
    r.hit = |r.vec;
    for (int i = 0; i < int'(NE); i++)
      if (r.vec[i]) begin r.lo = IW'(i); break; end
    for (int i = int'(NE) - 1; i >= 0; i--)
      if (r.vec[i]) begin r.hi = IW'(i); break; end
    return r;
  endfunction

  // Scoreboard: pushes at acceptance, checks outputs, tracks counters and stall stability.
  exp_t          e;
  logic          stalled = 1'b0;
  logic [11:0]   snap;
  logic [3:0]    c4 = '0;
  logic [15:0]   c16 = '0;
  always @(negedge clk) begin
    if (rst) begin
      check("reset_out_valid", 32'({lo_out_valid, hi_out_valid}), 32'(0));
      sb.delete();
      stalled = 1'b0;
      c4 = '0;
      c16 = '0;
      for (int i = 0; i < int'(NE); i++) begin
        m_val[i] = '0; m_mask[i] = '0; m_en[i] = 1'b0;
      end
    end else begin
      check("hit_cnt_lo", 32'(lo_hit_cnt), 32'(c4));
      check("hit_cnt_hi", 32'(hi_hit_cnt), 32'(c16));
      check("in_ready", 32'({lo_in_ready, hi_in_ready}),
            32'({!lo_out_valid || out_ready, !hi_out_valid || out_ready}));
      if (lo_out_valid || hi_out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 32'({lo_out_valid, hi_out_valid}), 32'(0));
        end else begin
          e = sb[0];
          check("lo_result", 32'({lo_out_valid, lo_out_hit, lo_out_vec, lo_out_idx}),
                32'({1'b1, e.hit, e.vec, e.lo}));
          check("hi_result", 32'({hi_out_valid, hi_out_hit, hi_out_vec, hi_out_idx}),
                32'({1'b1, e.hit, e.vec, e.hi}));
          if (stalled)
            check("stall_stable", 32'({lo_out_vec, lo_out_hit, lo_out_idx}), 32'(snap));
          if (out_ready) begin
            void'(sb.pop_front());
            if (e.hit) begin
              if (c4 != 4'hF) c4 = c4 + 4'd1;
              c16 = c16 + 16'd1;
            end
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            snap = {lo_out_vec, lo_out_hit, lo_out_idx};
          end
        end
      end
      if (in_valid && lo_in_ready) sb.push_back(model(in_data));
      if (cfg_we) begin
        m_val[cfg_idx]  = cfg_value;
        m_mask[cfg_idx] = cfg_mask;
        m_en[cfg_idx]   = cfg_en;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int idx, input logic [DW-1:0] v, input logic [DW-1:0] m, input logic en);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_value = v; cfg_mask = m; cfg_en = en;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit rnd);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 64 && !acc; c++) begin
      @(negedge clk);
      acc = lo_in_ready;
      tick();
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain(input bit rnd);
    for (int c = 0; c < 200 && sb.size() != 0; c++) begin
      tick();
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'(0));
    out_ready = 1'b1;
    tick();
  endtask

  // Single word with free downstream: result absent at N+1, present at N+2.
  task automatic apply_vec(input vec_t v);
    in_valid = 1'b1;
    in_data  = v.data;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check($sformatf("early_valid_%02h", v.data), 32'(lo_out_valid), 32'(0));
    @(negedge clk);
    check($sformatf("lo_vec_%02h", v.data), 32'({lo_out_valid, lo_out_hit, lo_out_vec, lo_out_idx}),
          32'({1'b1, v.hit, v.vec, v.lo}));
    check($sformatf("hi_vec_%02h", v.data), 32'({hi_out_valid, hi_out_hit, hi_out_vec, hi_out_idx}),
          32'({1'b1, v.hit, v.vec, v.hi}));
    tick();
  endtask

  vec_t vt [9];
  vec_t vz;

  initial begin
    // Hand-computed: e0={A0,F0,1}, e1={A5,FF,1}; then e3={0F,0F,1}, e5={C3,FF,0}, e6={81,81,1}.
    vt[0] = '{8'hA5, 8'h03, 1'b1, 3'd0, 3'd1};
    vt[1] = '{8'h5A, 8'h00, 1'b0, 3'd0, 3'd0};
    vt[2] = '{8'hAF, 8'h49, 1'b1, 3'd0, 3'd6};
    vt[3] = '{8'hC3, 8'h40, 1'b1, 3'd6, 3'd6};
    vt[4] = '{8'h0F, 8'h08, 1'b1, 3'd3, 3'd3};
    vt[5] = '{8'h5A, 8'h00, 1'b0, 3'd0, 3'd0};
    vt[6] = '{8'hA5, 8'h43, 1'b1, 3'd0, 3'd6};
    vt[7] = '{8'hFF, 8'h48, 1'b1, 3'd3, 3'd6};
    vt[8] = '{8'h81, 8'h40, 1'b1, 3'd6, 3'd6};
    vz    = '{8'hA5, 8'h00, 1'b0, 3'd0, 3'd0};

    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_value = '0; cfg_mask = '0; cfg_en = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("reset_state", 32'({lo_out_valid, lo_out_hit, lo_out_idx, lo_out_vec, lo_hit_cnt, lo_in_ready}),
          32'({1'b0, 1'b0, 3'd0, 8'h00, 4'h0, 1'b1}));
    tick();
    rst = 1'b0;
    tick();

    cfg(0, 8'hA0, 8'hF0, 1'b1);
    cfg(1, 8'hA5, 8'hFF, 1'b1);
    for (int i = 0; i < 2; i++) apply_vec(vt[i]);
    check("hit_cnt_after_miss", 32'(lo_hit_cnt), 32'(1));

    cfg(3, 8'h0F, 8'h0F, 1'b1);
    cfg(5, 8'hC3, 8'hFF, 1'b0);
    cfg(6, 8'h81, 8'h81, 1'b1);
    for (int i = 2; i < 9; i++) apply_vec(vt[i]);

    // Random stream under pseudo-random backpressure.
    for (int k = 0; k < 20; k++) send(8'($urandom), 1'b1);
    drain(1'b1);

    // Config write and word acceptance in the same cycle.
    cfg_we = 1'b1; cfg_idx = 3'd2; cfg_value = 8'h00; cfg_mask = 8'h00; cfg_en = 1'b1;
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    cfg_we = 1'b0;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("same_cycle_old_entry", 32'({lo_out_valid, lo_out_vec[2]}), 32'({1'b1, 1'b0}));
    tick();
    @(negedge clk);
    check("next_word_new_entry", 32'({lo_out_valid, lo_out_vec[2]}), 32'({1'b1, 1'b1}));
    tick();

    // e2 matches everything: drive the 4-bit counter into saturation.
    for (int k = 0; k < 20; k++) send(8'($urandom), 1'b0);
    drain(1'b0);
    check("hit_cnt_saturated", 32'(lo_hit_cnt), 32'(15));

    // Reset with two words in flight.
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    tick();
    in_valid = 1'b0;
    check("pre_reset_in_flight", 32'(lo_out_valid), 32'(1));
    rst = 1'b1;
    #1;
    check("async_reset", 32'({lo_out_valid, hi_out_valid, lo_hit_cnt}), 32'(0));
    tick(); tick();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_valid_after_reset", 32'({lo_out_valid, hi_out_valid}), 32'(0));
    end
    tick();
    apply_vec(vz);
    check("hit_cnt_after_reset", 32'(hi_hit_cnt), 32'(0));

    tick();
    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
